// File: rtl/serial_word_buffer_if.sv
// Bus bundle for serial_word_buffer: the external synchronous RAM port
// plus the flow-controlled playback (valid/ready) port.
//   master : the buffer (drives RAM address/write side and tx_data/tx_valid)
//   slave  : the RAM + downstream transmitter side
// Signals:
//   ram_we, ram_addr, ram_wdata  buffer -> RAM write strobe / address / data
//   ram_rdata                    RAM -> buffer, valid one cycle after ram_addr
//   tx_data, tx_valid            buffer -> transmitter playback word
//   tx_ready                     transmitter -> buffer accept
interface serial_word_buffer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output ram_we, ram_addr, ram_wdata, tx_data, tx_valid,
    input  ram_rdata, tx_ready
  );

  modport slave (
    input  ram_we, ram_addr, ram_wdata, tx_data, tx_valid,
    output ram_rdata, tx_ready
  );
endinterface

// File: rtl/serial_word_buffer.sv
// Serial capture / RAM playback engine. Receives async serial frames
// (start, DATA_W bits LSB first, [even parity], stop), writes each word to
// an external synchronous RAM at an incrementing address, and on a send
// request reads the words back in order onto a valid/ready port.
// Optional feature macro: SERIAL_PARITY_EN (adds an even-parity bit per frame).
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low
//   serial_in   async serial line, idle high
//   send        playback request, latched while receiving
//   bus         serial_word_buffer_if.master (RAM port + tx handshake)
//   word_count  words stored, 0..2**ADDR_W
//   busy        high whenever not in RX_IDLE
//   overflow    sticky: frame arrived while full
//   frame_err   sticky: bad stop (or parity) bit
//   send_done   one-cycle pulse at end of playback
module serial_word_buffer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                serial_in,
  input  logic                send,
  serial_word_buffer_if.master bus,
  output logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                overflow,
  output logic                frame_err,
  output logic                send_done
);

  localparam int unsigned TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] BIT_LOAD  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);

  typedef enum logic [3:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef SERIAL_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WRITE,
    PB_ADDR,
    PB_WAIT,
    PB_SHOW
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               pending_q, pending_d;
  logic               discard_q, discard_d;

  logic               ram_we_d;
  logic [ADDR_W-1:0]  ram_addr_d;
  logic [DATA_W-1:0]  ram_wdata_d;
  logic [DATA_W-1:0]  tx_data_d;
  logic               tx_valid_d;
  logic [CNT_W-1:0]   word_count_d;
  logic               busy_d, overflow_d, frame_err_d, send_done_d;

  logic               line_s;
  logic               timer_done;
  logic [CNT_W-1:0]   rd_ptr_inc;
  logic               in_playback;

  assign line_s      = sync_q[1];
  assign timer_done  = (timer_q == '0);
  assign rd_ptr_inc  = rd_ptr_q + CNT_W'(1);
  assign in_playback = (state_q == PB_ADDR) || (state_q == PB_WAIT) || (state_q == PB_SHOW);

  // Synchroniser resets to the idle-high level so reset release is not seen as a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], serial_in};
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RX_IDLE;
      timer_q       <= '0;
      idx_q         <= '0;
      shreg_q       <= '0;
      rd_ptr_q      <= '0;
      pending_q     <= 1'b0;
      discard_q     <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.tx_data   <= '0;
      bus.tx_valid  <= 1'b0;
      word_count    <= '0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
      frame_err     <= 1'b0;
      send_done     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      rd_ptr_q      <= rd_ptr_d;
      pending_q     <= pending_d;
      discard_q     <= discard_d;
      bus.ram_we    <= ram_we_d;
      bus.ram_addr  <= ram_addr_d;
      bus.ram_wdata <= ram_wdata_d;
      bus.tx_data   <= tx_data_d;
      bus.tx_valid  <= tx_valid_d;
      word_count    <= word_count_d;
      busy          <= busy_d;
      overflow      <= overflow_d;
      frame_err     <= frame_err_d;
      send_done     <= send_done_d;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    rd_ptr_d     = rd_ptr_q;
    discard_d    = discard_q;
    pending_d    = in_playback ? pending_q : (pending_q | send);
    ram_we_d     = 1'b0;
    ram_addr_d   = bus.ram_addr;
    ram_wdata_d  = bus.ram_wdata;
    tx_data_d    = bus.tx_data;
    tx_valid_d   = bus.tx_valid;
    word_count_d = word_count;
    overflow_d   = overflow;
    frame_err_d  = frame_err;
    send_done_d  = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        // Pending playback wins over a start edge seen in the same cycle.
        if (pending_q) begin
          pending_d = 1'b0;
          rd_ptr_d  = '0;
          if (word_count == '0) begin
            send_done_d = 1'b1;
          end else begin
            state_d    = PB_ADDR;
            ram_addr_d = '0;
          end
        end else if (!line_s) begin
          state_d = RX_START;
          timer_d = HALF_LOAD;
        end
      end

      RX_START: begin
        if (!timer_done) begin
          timer_d = timer_q - TMR_W'(1);
        end else if (!line_s) begin
          state_d   = RX_DATA;
          timer_d   = BIT_LOAD;
          idx_d     = '0;
          discard_d = 1'b0;
        end else begin
          state_d = RX_IDLE;
        end
      end

      RX_DATA: begin
        if (!timer_done) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          // LSB-first: new bit enters at the top and walks down.
          shreg_d = (shreg_q >> 1) | (DATA_W'(line_s) << (DATA_W - 1));
          timer_d = BIT_LOAD;
          if (idx_q == LAST_IDX) begin
`ifdef SERIAL_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

`ifdef SERIAL_PARITY_EN
      RX_PARITY: begin
        if (!timer_done) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          timer_d = BIT_LOAD;
          state_d = RX_STOP;
          // Even parity: parity bit equals the XOR of the data bits.
          if (line_s != ^shreg_q) begin
            discard_d   = 1'b1;
            frame_err_d = 1'b1;
          end
        end
      end
`endif

      RX_STOP: begin
        if (!timer_done) begin
          timer_d = timer_q - TMR_W'(1);
        end else if (discard_q) begin
          // Bad frame: hold here until the line returns high.
          if (line_s) state_d = RX_IDLE;
        end else if (line_s) begin
          state_d = RX_WRITE;
          if (!word_count[ADDR_W]) begin
            ram_we_d     = 1'b1;
            ram_addr_d   = word_count[ADDR_W-1:0];
            ram_wdata_d  = shreg_q;
            word_count_d = word_count + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          discard_d   = 1'b1;
        end
      end

      RX_WRITE: state_d = RX_IDLE;

      PB_ADDR: state_d = PB_WAIT;

      PB_WAIT: begin
        state_d    = PB_SHOW;
        tx_data_d  = bus.ram_rdata;
        tx_valid_d = 1'b1;
      end

      PB_SHOW: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          rd_ptr_d   = rd_ptr_inc;
          if (rd_ptr_inc == word_count) begin
            word_count_d = '0;
            send_done_d  = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            state_d    = PB_ADDR;
            ram_addr_d = rd_ptr_inc[ADDR_W-1:0];
          end
        end
      end

      default: state_d = RX_IDLE;
    endcase

    busy_d = (state_d != RX_IDLE);
  end

endmodule

// File: doc/serial_word_buffer.md
# serial_word_buffer

Parametrised serial-to-RAM capture and playback engine. Receives asynchronous serial frames (start bit, DATA_W data bits LSB first, stop bit) on one line, assembles each frame into a word and writes it to an external synchronous RAM at an incrementing address. On a send request it reads the stored words back in order and hands them to a downstream transmitter over a valid/ready handshake. Successor to the original fixed 8-bit receive/send controller; it adds bit-rate timing, framing checks, a full/overflow limit and a flow-controlled playback path.

## Interface
- DATA_W, 8: data bits per frame and RAM word width (1..32)
- ADDR_W, 8: RAM address width; buffer depth is 2**ADDR_W words
- CLKS_PER_BIT, 16: clk cycles per serial bit (min 4, even)

- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- serial_in  in  1  async serial line, idle high
- send  in  1  playback request pulse; level-sensitive, sampled each cycle
- ram_we  out  1  RAM write strobe, one cycle per word
- ram_addr  out  ADDR_W  RAM address for write or read
- ram_wdata  out  DATA_W  assembled word
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_addr is presented
- tx_data  out  DATA_W  playback word
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  downstream accepts tx_data this cycle
- word_count  out  ADDR_W+1  words stored, 0..2**ADDR_W
- busy  out  1  high in any state other than RX_IDLE
- overflow  out  1  sticky; frame received while full
- frame_err  out  1  sticky; stop bit (or parity) bad
- send_done  out  1  one-cycle pulse when playback completes

## Operation
- serial_in passes through a 2-flop synchroniser; all decisions use the synchronised value.
- States: RX_IDLE, RX_START, RX_DATA, [RX_PARITY], RX_STOP, RX_WRITE, PB_ADDR, PB_WAIT, PB_SHOW.
- RX_IDLE: low synchronised line -> RX_START, bit timer loaded.
- RX_START: after CLKS_PER_BIT/2 cycles, line still low -> RX_DATA; high -> glitch, back to RX_IDLE, nothing recorded.
- RX_DATA: sample every CLKS_PER_BIT cycles, shift into bit index 0..DATA_W-1 (LSB first); after last bit -> RX_STOP (or RX_PARITY).
- RX_STOP: sample at mid-bit. High -> RX_WRITE. Low -> frame_err set, word discarded, wait for line high, RX_IDLE.
- RX_WRITE (one cycle): if word_count < 2**ADDR_W: ram_we=1, ram_addr=word_count[ADDR_W-1:0], ram_wdata=word, word_count+1. If full: no write, overflow set. Then RX_IDLE.
- send is latched into a pending flag in any RX state; acted on only from RX_IDLE (frame in progress completes and is written first). send during PB states ignored.
- Playback from RX_IDLE with pending send: read pointer = 0. word_count == 0 -> send_done pulse, stay RX_IDLE.
- PB_ADDR: ram_addr=read pointer -> PB_WAIT (one cycle RAM latency) -> PB_SHOW: tx_data captured from ram_rdata, tx_valid=1 until tx_ready. On accept: pointer+1; pointer == word_count -> word_count=0, send_done pulse, RX_IDLE; else PB_ADDR.
- Serial input is ignored during playback; frames arriving then are lost.
- overflow and frame_err clear only on reset.

## Timing
- Reset values: ram_we=0, ram_addr=0, ram_wdata=0, tx_data=0, tx_valid=0, word_count=0, busy=0, overflow=0, frame_err=0, send_done=0; state RX_IDLE, pending send cleared. Reset mid-frame or mid-playback aborts with no further RAM access.
- Start edge to ram_we: 2 (sync) + CLKS_PER_BIT/2 + (DATA_W+1)·CLKS_PER_BIT + 1 cycles, ±1 for edge phase.
- Playback: minimum 3 cycles per word (PB_ADDR, PB_WAIT, PB_SHOW with tx_ready high); tx_valid rises 2 cycles after PB_ADDR entry.
- tx_data/tx_valid stable while tx_valid=1 and tx_ready=0.
- ram_we and a read address never coincide.

## Configuration
- SERIAL_PARITY_EN defined: frame carries an even-parity bit after data (RX_PARITY state, one bit period); mismatch sets frame_err and discards the word; latency grows by CLKS_PER_BIT.
- Not defined: no parity bit, RX_PARITY state absent, stop follows last data bit.

## Test plan
- DATA_W=8, CLKS_PER_BIT=4: frame 0xA5 -> ram_we once, ram_addr=0, ram_wdata=0xA5, word_count=1.
- 0x3C, 0x81, 0xFF then send pulse, tx_ready held high -> tx_data 0x3C,0x81,0xFF in order, send_done one cycle, word_count=0.
- Same, tx_ready low 5 cycles on second word -> tx_data=0x81 and tx_valid held steady, no extra RAM read.
- ADDR_W=2: 5 frames -> 4 writes at addresses 0..3, word_count=4, overflow=1, fifth word not written.
- Stop bit driven low -> frame_err=1, no ram_we; 2-cycle low glitch in idle -> no state change beyond RX_START.
- send mid-frame -> frame written first, then playback; reset low mid-playback -> all outputs at reset values next edge.
